mem_store_buffer: RTL

//  Write-back store buffer between the MEM pipeline stage and dm_4k.
//  CPU stores are queued in a FIFO and drained to dm_4k when the data-memory

---
 rtl/mem_store_buffer.sv | 114 +++++++++++
 1 files changed

// File: rtl/mem_store_buffer.sv
// Write-back store buffer between the MEM stage and dm_4k: stores queue in a
// FIFO and drain when the port is free, loads bypass it and stall on word hits.
module mem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req_valid,
    input  logic             i_req_we,
    input  logic [11:0]      i_req_addr,
    input  logic [31:0]      i_req_wdata,
    input  logic [1:0]       i_req_mode,
    output logic             o_req_stall,
    output logic [31:0]      o_load_data,
    input  logic             i_dm_grant,
    output logic [11:0]      o_dm_addr,
    output logic [31:0]      o_dm_din,
    output logic             o_dm_DMWr,
    output logic [1:0]       o_dm_mode,
    input  logic [31:0]      i_dm_dout,
    output logic [PTR_W:0]   o_sb_count,
    output logic             o_sb_empty,
    output logic             o_sb_full
);

    logic [11:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [1:0]       r_mode [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_empty;
    logic             w_full;
    logic             w_hit;
    logic             w_load_go;
    logic             w_drain;
    logic             w_accept;
    logic [PTR_W-1:0] w_offset;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (PTR_W+1)'(DEPTH));

    // An entry is live when its distance from head is below the current count.
    always_comb begin
        w_hit    = 1'b0;
        w_offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_offset = PTR_W'(i) - r_head;
            if (({1'b0, w_offset} < r_count) && (r_addr[i][11:2] == i_req_addr[11:2])) begin
                w_hit = 1'b1;
            end
        end
        w_hit = w_hit & i_req_valid & ~i_req_we;
    end

    assign w_load_go = rst_n & i_req_valid & ~i_req_we & i_dm_grant & ~w_hit;
    assign w_drain   = rst_n & ~w_load_go & i_dm_grant & ~w_empty;
    assign w_accept  = rst_n & i_req_valid & i_req_we & ~w_full;

    always_comb begin
        o_dm_addr   = '0;
        o_dm_din    = '0;
        o_dm_mode   = '0;
        o_dm_DMWr   = 1'b0;
        o_load_data = '0;
        if (w_load_go) begin
            o_dm_addr   = i_req_addr;
            o_dm_mode   = i_req_mode;
            o_load_data = i_dm_dout;
        end else if (w_drain) begin
            o_dm_addr = r_addr[r_head];
            o_dm_din  = r_data[r_head];
            o_dm_mode = r_mode[r_head];
            o_dm_DMWr = 1'b1;
        end
    end

    assign o_req_stall = rst_n & i_req_valid & (i_req_we ? w_full : (~i_dm_grant | w_hit));
    assign o_sb_count  = r_count;
    assign o_sb_empty  = w_empty;
    assign o_sb_full   = w_full;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr[r_tail] <= i_req_addr;
            r_data[r_tail] <= i_req_wdata;
            r_mode[r_tail] <= i_req_mode;
        end
    end

    // Accept and drain in the same cycle leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_drain) begin
                r_head <= r_head + 1'b1;
            end
            if (w_accept && !w_drain) begin
                r_count <= r_count + 1'b1;
            end else if (!w_accept && w_drain) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
